// File: rtl/add_reservation_station_if.sv
// Issue, CDB and adder-dispatch signals of the adder reservation station.
// The master modport drives issue/CDB/adder status; the slave (the station) drives the rest.
interface add_reservation_station_if #(
    parameter int DATA_W = 8,
    parameter int TAG_W  = 3
);
    logic              issue_valid;
    logic              issue_ready;
    logic [DATA_W-1:0] issue_src1_val;
    logic [TAG_W-1:0]  issue_src1_tag;
    logic [DATA_W-1:0] issue_src2_val;
    logic [TAG_W-1:0]  issue_src2_tag;
    logic [TAG_W-1:0]  issue_tag;
    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_data;
    logic              add_status;
    logic [TAG_W-1:0]  add_tag_ip;
    logic [DATA_W-1:0] source_reg1;
    logic [DATA_W-1:0] source_reg2;
    logic [2:0]        rs_count;

    modport master (
        output issue_valid, issue_src1_val, issue_src1_tag, issue_src2_val, issue_src2_tag,
        output cdb_valid, cdb_tag, cdb_data, add_status,
        input  issue_ready, issue_tag, add_tag_ip, source_reg1, source_reg2, rs_count
    );

    modport slave (
        input  issue_valid, issue_src1_val, issue_src1_tag, issue_src2_val, issue_src2_tag,
        input  cdb_valid, cdb_tag, cdb_data, add_status,
        output issue_ready, issue_tag, add_tag_ip, source_reg1, source_reg2, rs_count
    );
endinterface

// File: rtl/add_reservation_station.sv
// Tomasulo reservation station for the adder: holds issued adds until both operands
// are known, dispatches one ready entry at a time, and frees entries on their own CDB tag.
module add_reservation_station #(
    parameter int NUM_ENTRIES = 3,
    parameter int DATA_W      = 8,
    parameter int TAG_W       = 3,
    parameter int TAG_BASE    = 1
) (
    input logic clk,
    input logic rst_n,
    add_reservation_station_if.slave bus
);
    localparam int N = NUM_ENTRIES;

    logic [N-1:0]      busy_q, busy_d, disp_q, disp_d;
    logic [DATA_W-1:0] v1_q [N];
    logic [DATA_W-1:0] v1_d [N];
    logic [DATA_W-1:0] v2_q [N];
    logic [DATA_W-1:0] v2_d [N];
    logic [TAG_W-1:0]  q1_q [N];
    logic [TAG_W-1:0]  q1_d [N];
    logic [TAG_W-1:0]  q2_q [N];
    logic [TAG_W-1:0]  q2_d [N];
    logic [TAG_W-1:0]  add_tag_q, add_tag_d;
    logic [DATA_W-1:0] src1_q, src1_d, src2_q, src2_d;
    logic [2:0]        cnt_q, cnt_d;

    logic       free_found, cand_found, cdb_hit, do_issue, do_dispatch;
    logic [2:0] free_idx, cand_idx;

    function automatic logic [TAG_W-1:0] own_tag(input int i);
        return TAG_W'(TAG_BASE + i);
    endfunction

    // Priority pickers scan downward so the lowest index wins.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        cand_found = 1'b0;
        cand_idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (!busy_q[i]) begin
                free_found = 1'b1;
                free_idx   = 3'(i);
            end
            if (busy_q[i] && !disp_q[i] && q1_q[i] == '0 && q2_q[i] == '0) begin
                cand_found = 1'b1;
                cand_idx   = 3'(i);
            end
        end
    end

    assign cdb_hit     = bus.cdb_valid && (bus.cdb_tag != '0);
    assign do_issue    = bus.issue_valid && free_found;
    assign do_dispatch = cand_found && !bus.add_status && (add_tag_q == '0);

    always_comb begin
        busy_d    = busy_q;
        disp_d    = disp_q;
        v1_d      = v1_q;
        v2_d      = v2_q;
        q1_d      = q1_q;
        q2_d      = q2_q;
        add_tag_d = '0;
        src1_d    = src1_q;
        src2_d    = src2_q;
        cnt_d     = '0;
        for (int i = 0; i < N; i++) begin
            if (busy_q[i]) begin
                if (cdb_hit && q1_q[i] == bus.cdb_tag) begin
                    v1_d[i] = bus.cdb_data;
                    q1_d[i] = '0;
                end
                if (cdb_hit && q2_q[i] == bus.cdb_tag) begin
                    v2_d[i] = bus.cdb_data;
                    q2_d[i] = '0;
                end
                // Only a dispatched entry can be completed by its own tag.
                if (bus.cdb_valid && bus.cdb_tag == own_tag(i) && disp_q[i]) begin
                    busy_d[i] = 1'b0;
                    disp_d[i] = 1'b0;
                end
            end
            if (do_dispatch && 3'(i) == cand_idx) begin
                add_tag_d = own_tag(i);
                src1_d    = v1_q[i];
                src2_d    = v2_q[i];
                disp_d[i] = 1'b1;
            end
            if (do_issue && 3'(i) == free_idx) begin
                busy_d[i] = 1'b1;
                disp_d[i] = 1'b0;
                v1_d[i]   = bus.issue_src1_val;
                q1_d[i]   = bus.issue_src1_tag;
                v2_d[i]   = bus.issue_src2_val;
                q2_d[i]   = bus.issue_src2_tag;
                if (cdb_hit && bus.issue_src1_tag == bus.cdb_tag) begin
                    v1_d[i] = bus.cdb_data;
                    q1_d[i] = '0;
                end
                if (cdb_hit && bus.issue_src2_tag == bus.cdb_tag) begin
                    v2_d[i] = bus.cdb_data;
                    q2_d[i] = '0;
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            cnt_d = cnt_d + 3'(busy_d[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q    <= '0;
            disp_q    <= '0;
            add_tag_q <= '0;
            src1_q    <= '0;
            src2_q    <= '0;
            cnt_q     <= '0;
            for (int i = 0; i < N; i++) begin
                v1_q[i] <= '0;
                v2_q[i] <= '0;
                q1_q[i] <= '0;
                q2_q[i] <= '0;
            end
        end else begin
            busy_q    <= busy_d;
            disp_q    <= disp_d;
            add_tag_q <= add_tag_d;
            src1_q    <= src1_d;
            src2_q    <= src2_d;
            cnt_q     <= cnt_d;
            for (int i = 0; i < N; i++) begin
                v1_q[i] <= v1_d[i];
                v2_q[i] <= v2_d[i];
                q1_q[i] <= q1_d[i];
                q2_q[i] <= q2_d[i];
            end
        end
    end

    assign bus.issue_ready = free_found;
    assign bus.issue_tag   = TAG_W'(TAG_BASE) + TAG_W'(free_idx);
    assign bus.add_tag_ip  = add_tag_q;
    assign bus.source_reg1 = src1_q;
    assign bus.source_reg2 = src2_q;
    assign bus.rs_count    = cnt_q;
endmodule

// File: tb/tb_add_reservation_station.sv
// Directed bench for add_reservation_station: issue, CDB capture/bypass, full,
// adder back-pressure and asynchronous reset, against hand-computed values.
module tb_add_reservation_station;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    add_reservation_station_if #(.DATA_W(8), .TAG_W(3)) bus ();

    add_reservation_station #(
        .NUM_ENTRIES(3), .DATA_W(8), .TAG_W(3), .TAG_BASE(1)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic idle_inputs();
        bus.issue_valid    = 1'b0;
        bus.issue_src1_val = '0;
        bus.issue_src1_tag = '0;
        bus.issue_src2_val = '0;
        bus.issue_src2_tag = '0;
        bus.cdb_valid      = 1'b0;
        bus.cdb_tag        = '0;
        bus.cdb_data       = '0;
        bus.add_status     = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic set_issue(input logic [7:0] v1, input logic [2:0] t1,
                             input logic [7:0] v2, input logic [2:0] t2);
        bus.issue_valid    = 1'b1;
        bus.issue_src1_val = v1;
        bus.issue_src1_tag = t1;
        bus.issue_src2_val = v2;
        bus.issue_src2_tag = t2;
    endtask

    task automatic set_cdb(input logic [2:0] t, input logic [7:0] d);
        bus.cdb_valid = 1'b1;
        bus.cdb_tag   = t;
        bus.cdb_data  = d;
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        #12;
        check("rst_tag_ip", 32'(bus.add_tag_ip), 0);
        check("rst_src1", 32'(bus.source_reg1), 0);
        check("rst_src2", 32'(bus.source_reg2), 0);
        check("rst_count", 32'(bus.rs_count), 0);
        check("rst_ready", 32'(bus.issue_ready), 1);
        check("rst_issue_tag", 32'(bus.issue_tag), 1);
        @(negedge clk);
        rst_n = 1'b1;

        // Ready operands at issue: dispatch one cycle after the issue edge.
        set_issue(8'h05, 3'd0, 8'h03, 3'd0);
        #1;
        check("t1_issue_tag", 32'(bus.issue_tag), 1);
        tick();
        idle_inputs();
        check("t1_count", 32'(bus.rs_count), 1);
        check("t1_no_disp_yet", 32'(bus.add_tag_ip), 0);
        tick();
        check("t1_disp_tag", 32'(bus.add_tag_ip), 1);
        check("t1_src1", 32'(bus.source_reg1), 32'h05);
        check("t1_src2", 32'(bus.source_reg2), 32'h03);
        tick();
        check("t1_pulse_end", 32'(bus.add_tag_ip), 0);
        check("t1_src1_hold", 32'(bus.source_reg1), 32'h05);
        set_cdb(3'd1, 8'h08);
        tick();
        idle_inputs();
        check("t1_freed", 32'(bus.rs_count), 0);

        // Pending operand 1 filled by a later CDB broadcast.
        set_issue(8'hee, 3'd2, 8'h04, 3'd0);
        tick();
        idle_inputs();
        tick();
        check("t2_wait", 32'(bus.add_tag_ip), 0);
        set_cdb(3'd2, 8'h10);
        tick();
        idle_inputs();
        check("t2_capture_no_disp", 32'(bus.add_tag_ip), 0);
        tick();
        check("t2_disp_tag", 32'(bus.add_tag_ip), 1);
        check("t2_src1", 32'(bus.source_reg1), 32'h10);
        check("t2_src2", 32'(bus.source_reg2), 32'h04);
        set_cdb(3'd1, 8'h14);
        tick();
        idle_inputs();
        check("t2_freed", 32'(bus.rs_count), 0);

        // Issue-cycle bypass of operand 2.
        set_issue(8'h07, 3'd0, 8'hcc, 3'd3);
        set_cdb(3'd3, 8'h22);
        tick();
        idle_inputs();
        check("t3_count", 32'(bus.rs_count), 1);
        tick();
        check("t3_disp_tag", 32'(bus.add_tag_ip), 1);
        check("t3_src1", 32'(bus.source_reg1), 32'h07);
        check("t3_src2", 32'(bus.source_reg2), 32'h22);

        // Fill all entries with distinct pending producers.
        do_reset();
        set_issue(8'h00, 3'd7, 8'h01, 3'd0);
        #1;
        check("t4_tag_e0", 32'(bus.issue_tag), 1);
        tick();
        set_issue(8'h00, 3'd5, 8'h02, 3'd0);
        #1;
        check("t4_tag_e1", 32'(bus.issue_tag), 2);
        tick();
        set_issue(8'h00, 3'd6, 8'h03, 3'd0);
        #1;
        check("t4_tag_e2", 32'(bus.issue_tag), 3);
        tick();
        check("t4_full_ready", 32'(bus.issue_ready), 0);
        check("t4_full_count", 32'(bus.rs_count), 3);
        set_issue(8'h09, 3'd0, 8'h09, 3'd0);
        tick();
        idle_inputs();
        check("t4_ignored_count", 32'(bus.rs_count), 3);
        tick();
        check("t4_ignored_no_disp", 32'(bus.add_tag_ip), 0);
        set_cdb(3'd2, 8'h99);
        tick();
        idle_inputs();
        check("t4_own_tag_undispatched", 32'(bus.rs_count), 3);
        set_cdb(3'd5, 8'h55);
        tick();
        idle_inputs();
        check("t4_capture", 32'(bus.add_tag_ip), 0);
        tick();
        check("t4_disp_tag", 32'(bus.add_tag_ip), 2);
        check("t4_disp_src1", 32'(bus.source_reg1), 32'h55);
        check("t4_disp_src2", 32'(bus.source_reg2), 32'h02);
        check("t4_still_full", 32'(bus.issue_ready), 0);
        set_cdb(3'd2, 8'h57);
        tick();
        idle_inputs();
        check("t4_free_count", 32'(bus.rs_count), 2);
        check("t4_free_ready", 32'(bus.issue_ready), 1);
        check("t4_free_tag", 32'(bus.issue_tag), 2);

        // Adder busy holds off dispatch; released entries go out one idle cycle apart.
        do_reset();
        bus.add_status = 1'b1;
        set_issue(8'h11, 3'd0, 8'h12, 3'd0);
        tick();
        set_issue(8'h21, 3'd0, 8'h22, 3'd0);
        tick();
        bus.issue_valid = 1'b0;
        check("t5_count", 32'(bus.rs_count), 2);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("t5_stalled", 32'(bus.add_tag_ip), 0);
        end
        bus.add_status = 1'b0;
        tick();
        check("t5_first_tag", 32'(bus.add_tag_ip), 1);
        check("t5_first_src1", 32'(bus.source_reg1), 32'h11);
        check("t5_first_src2", 32'(bus.source_reg2), 32'h12);
        tick();
        check("t5_gap", 32'(bus.add_tag_ip), 0);
        tick();
        check("t5_second_tag", 32'(bus.add_tag_ip), 2);
        check("t5_second_src1", 32'(bus.source_reg1), 32'h21);
        check("t5_second_src2", 32'(bus.source_reg2), 32'h22);

        // Asynchronous reset while a dispatch pulse is on the outputs.
        do_reset();
        set_issue(8'h33, 3'd0, 8'h44, 3'd0);
        tick();
        idle_inputs();
        tick();
        check("t6_pre_disp", 32'(bus.add_tag_ip), 1);
        rst_n = 1'b0;
        #1;
        check("t6_async_tag_ip", 32'(bus.add_tag_ip), 0);
        check("t6_async_src1", 32'(bus.source_reg1), 0);
        check("t6_async_src2", 32'(bus.source_reg2), 0);
        check("t6_async_count", 32'(bus.rs_count), 0);
        check("t6_async_ready", 32'(bus.issue_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("t6_no_disp", 32'(bus.add_tag_ip), 0);
        end
        check("t6_count_after", 32'(bus.rs_count), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/add_reservation_station.md
# add_reservation_station

Reservation station feeding the Tomasulo adder functional unit (Adder_Unit). Accepts issued add instructions, holds them until both operands are available (directly at issue or by snooping the common data bus, CDB), dispatches ready entries to the adder as operand pair plus tag, and frees each entry when its own tag is broadcast on the CDB. It is the issuing side of the adder's tag/operand interface.

## Interface

Parameters:
- NUM_ENTRIES, 3: reservation-station entries (max 7).
- DATA_W, 8: operand/result width.
- TAG_W, 3: tag width; tag 0 means "no producer / value valid".
- TAG_BASE, 1: tag of entry 0; entry i owns tag TAG_BASE+i (must be nonzero, TAG_BASE+NUM_ENTRIES-1 < 2^TAG_W).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- issue_valid  input  1  issue request this cycle.
- issue_ready  output  1  at least one free entry (combinational from registered busy bits).
- issue_src1_val  input  DATA_W  operand 1 value, used when issue_src1_tag==0.
- issue_src1_tag  input  TAG_W  producer tag of operand 1.
- issue_src2_val  input  DATA_W  operand 2 value.
- issue_src2_tag  input  TAG_W  producer tag of operand 2.
- issue_tag  output  TAG_W  tag the entry allocated on this cycle's issue receives (combinational; valid when issue_ready).
- cdb_valid  input  1  CDB broadcast valid.
- cdb_tag  input  TAG_W  CDB producer tag.
- cdb_data  input  DATA_W  CDB result value.
- add_status  input  1  adder busy (1 = cannot accept).
- add_tag_ip  output  TAG_W  dispatched tag; 0 = no dispatch. Registered.
- source_reg1  output  DATA_W  dispatched operand 1. Registered.
- source_reg2  output  DATA_W  dispatched operand 2. Registered.
- rs_count  output  3  number of busy entries. Registered.

## Operation

- Entry state: busy, dispatched, v1, q1, v2, q2. Operand ready when its q==0.
- Issue: on issue_valid && issue_ready, allocate lowest-index free entry; busy=1, dispatched=0, copy tags/values. If a source tag is nonzero and cdb_valid with cdb_tag equal to it in the same cycle, capture cdb_data and set q=0 (issue-cycle bypass). issue_valid while !issue_ready is ignored (no state change).
- CDB snoop: each cycle, every busy entry with q1 or q2 equal to cdb_tag (cdb_valid=1, cdb_tag≠0) captures cdb_data and clears that q. Both operands may match in the same cycle.
- Dispatch: candidate = lowest-index entry with busy && !dispatched && q1==0 && q2==0 (from registered state). Dispatch when a candidate exists, add_status==0, and add_tag_ip==0 (no dispatch in previous cycle). Registers add_tag_ip=entry tag, source_reg1=v1, source_reg2=v2, sets dispatched=1. add_tag_ip returns to 0 the next cycle; source_reg1/2 hold their last values.
- Completion: cdb_valid with cdb_tag matching a busy, dispatched entry's own tag clears busy (entry free next cycle). CDB match on a not-yet-dispatched entry's own tag is ignored.
- rs_count = popcount(busy) after the edge's updates.

## Timing

- Reset (rst_n low, asynchronous): all entries free, add_tag_ip=0, source_reg1=0, source_reg2=0, rs_count=0; issue_ready=1, issue_tag=TAG_BASE. Reset mid-dispatch discards all entries; no pending dispatch survives.
- Issue at edge N with ready operands: earliest add_tag_ip≠0 after edge N+1 (one-cycle issue-to-dispatch). Operand captured from CDB at edge N: dispatch earliest after edge N+1.
- Dispatch pulses are exactly one cycle wide and at least one idle cycle apart.
- Entry freed at edge N is not issuable until after edge N (issue_ready derives from registered busy); simultaneous free and issue do not target the same entry in the same cycle.
- Full: with all entries busy issue_ready=0; freeing an entry raises issue_ready the next cycle.

## Test plan

- Reset then issue src1=8'h05/tag0, src2=8'h03/tag0 -> issue_tag=1; one cycle later add_tag_ip=1, source_reg1=05, source_reg2=03 for one cycle; rs_count=1; CDB tag1 data 08 -> rs_count=0.
- Issue with src1_tag=2 (pending); CDB tag2 data 8'h10 two cycles later -> entry captures 10, dispatches next cycle with source_reg1=10.
- Issue with src2_tag=3 while CDB broadcasts tag3 data 8'h22 same cycle -> bypass, dispatch next cycle with source_reg2=22.
- Fill 3 entries -> issue_ready=0, extra issue_valid ignored, rs_count=3; free entry 2 via CDB -> issue_ready=1 next cycle, issue_tag=2.
- Two ready entries with add_status=1 held 4 cycles -> no dispatch; drop add_status -> tag1 dispatched, one idle cycle, then tag2.
- Assert rst_n low while add_tag_ip=1 -> outputs immediately 0, rs_count=0, no dispatch after release.
